// File: rtl/eeprom_reader.sv
// eeprom_reader: burst reader for a parallel asynchronous EEPROM.
//
// A start in IDLE with a non-zero length captures base_addr/length and walks
// the EEPROM one byte at a time: SETUP (chip select, 1 cycle), ACCESS (output
// enable, ACCESS_CYCLES cycles, data registered on the last edge), HOLD (bus
// released, byte offered on rd_data/rd_valid until rd_ready). A zero-length
// start only pulses done. done pulses one cycle after the final handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               burst request, sampled only in IDLE
//   base_addr[15:0]     first address, captured with start
//   length[7:0]         byte count, captured with start (0 = done only)
//   ee_cs_n, ee_oe_n    EEPROM chip select / output enable (active low)
//   ee_addr[15:0]       EEPROM address, holds last value when idle
//   ee_data[7:0]        EEPROM data bus
//   rd_data, rd_valid   delivered byte and its valid flag
//   rd_ready            consumer accept
//   busy                FSM not in IDLE
//   done                one-cycle completion pulse
//   checksum[7:0]       mod-256 sum of delivered bytes of the current burst
//
// Build option: define EEPROM_READER_CHECKSUM_EN to enable the checksum;
// otherwise checksum is tied to 0x00.

module eeprom_reader #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [7:0]  length,
  output logic        ee_cs_n,
  output logic        ee_oe_n,
  output logic [15:0] ee_addr,
  input  logic [7:0]  ee_data,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  checksum
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  logic [15:0] addr_q;
  logic [7:0]  remain_q;
  logic [3:0]  acc_cnt;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        done_q;

  logic start_ok;
  logic handshake;

  assign start_ok  = (state == IDLE) && start && (length != 8'd0);
  assign handshake = (state == HOLD) && valid_q && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      acc_cnt  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (length != 8'd0) begin
              addr_q   <= base_addr;
              remain_q <= length;
              state    <= SETUP;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          acc_cnt <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (acc_cnt == ACC_LAST) begin
            data_q  <= ee_data;
            valid_q <= 1'b1;
            state   <= HOLD;
          end else begin
            acc_cnt <= acc_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (handshake) begin
            valid_q  <= 1'b0;
            remain_q <= remain_q - 8'd1;
            if (remain_q == 8'd1) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              // 16-bit add wraps 0xFFFF -> 0x0000 naturally.
              addr_q <= addr_q + 16'd1;
              state  <= SETUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus strobes decode straight from state so reset releases them at once.
  assign ee_cs_n  = !((state == SETUP) || (state == ACCESS));
  assign ee_oe_n  = (state != ACCESS);
  assign ee_addr  = addr_q;
  assign rd_data  = data_q;
  assign rd_valid = valid_q;
  assign busy     = (state != IDLE);
  assign done     = done_q;

`ifdef EEPROM_READER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (handshake) begin
      sum_q <= sum_q + data_q;
    end
  end

  assign checksum = sum_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_eeprom_reader.sv
// Directed bench for eeprom_reader with a small EEPROM model.
module tb_eeprom_reader;

  localparam int unsigned AC = 2;

`ifdef EEPROM_READER_CHECKSUM_EN
  localparam logic [7:0] CSUM5 = 8'h32;
  localparam logic [7:0] CSUM2 = 8'h28;
`else
  localparam logic [7:0] CSUM5 = 8'h00;
  localparam logic [7:0] CSUM2 = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  length = '0;
  logic        ee_cs_n, ee_oe_n;
  logic [15:0] ee_addr;
  logic [7:0]  ee_data;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        busy, done;
  logic [7:0]  checksum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  eeprom_reader #(.ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .ee_cs_n(ee_cs_n), .ee_oe_n(ee_oe_n), .ee_addr(ee_addr),
    .ee_data(ee_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .busy(busy), .done(done), .checksum(checksum)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h01;
      16'h0001: return 8'h03;
      16'h0002: return 8'h06;
      16'h0003: return 8'h0E;
      16'h0004: return 8'h1A;
      16'hFFFE: return 8'h77;
      16'hFFFF: return 8'h88;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Bus floats to a marker value unless the part is selected and enabled.
  assign ee_data = (!ee_cs_n && !ee_oe_n) ? mem_byte(ee_addr) : 8'hA5;

  // Results of the last run_burst.
  logic [7:0]  got_data[$];
  logic [15:0] got_addr[$];
  int          got_vcyc[$];
  int          done_cyc, done_cnt, busy_bad, overlap, cs_low, oe_low;

  // Drives one burst with rd_ready high and records what the DUT does.
  // Cycle 1 is the first negedge after start was taken.
  task automatic run_burst(input logic [15:0] b, input logic [7:0] l,
                           input int max_cyc, input int stray_at);
    int extra;
    got_data.delete(); got_addr.delete(); got_vcyc.delete();
    done_cyc = -1; done_cnt = 0; busy_bad = 0; overlap = 0;
    cs_low = 0; oe_low = 0; extra = 0;
    rd_ready = 1'b1;
    base_addr = b; length = l; start = 1'b1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_valid) begin
        got_data.push_back(rd_data);
        got_addr.push_back(ee_addr);
        got_vcyc.push_back(i);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = i;
      end
      if (done && rd_valid) overlap++;
      if (!ee_cs_n) cs_low++;
      if (!ee_oe_n) oe_low++;
      if (done_cyc < 0 && l != 8'd0 && !busy) busy_bad++;
      if (i == stray_at) begin
        base_addr = 16'h0100; length = 8'd9; start = 1'b1;
      end
      if (done_cyc >= 0) begin
        extra++;
        if (extra > 2) break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    if ({ee_cs_n, ee_oe_n, ee_addr, rd_data, rd_valid, busy, done, checksum} !==
        {1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_state got cs=%b oe=%b addr=%h data=%h v=%b busy=%b done=%b cs=%h",
               ee_cs_n, ee_oe_n, ee_addr, rd_data, rd_valid, busy, done, checksum);
    end
    n_cmp++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_burst5;
    logic [7:0] exp_d[5] = '{8'h01, 8'h03, 8'h06, 8'h0E, 8'h1A};
    run_burst(16'h0000, 8'd5, 60, -1);
    if (got_data.size() != 5) begin
      n_bad++; $display("FAIL b5_count got %0d exp 5", got_data.size());
    end
    n_cmp++;
    for (int k = 0; k < 5 && k < got_data.size(); k++) begin
      if (got_data[k] !== exp_d[k]) begin
        n_bad++; $display("FAIL b5_data[%0d] got %h exp %h", k, got_data[k], exp_d[k]);
      end
      n_cmp++;
      if (got_vcyc[k] != int'(AC) + 2 + k * (int'(AC) + 2)) begin
        n_bad++; $display("FAIL b5_valid_cycle[%0d] got %0d exp %0d", k, got_vcyc[k],
                          int'(AC) + 2 + k * (int'(AC) + 2));
      end
      n_cmp++;
    end
    if (done_cyc != 5 * (int'(AC) + 2) + 1 || done_cnt != 1) begin
      n_bad++; $display("FAIL b5_done got cyc=%0d cnt=%0d exp cyc=%0d cnt=1",
                        done_cyc, done_cnt, 5 * (int'(AC) + 2) + 1);
    end
    n_cmp++;
    if (busy_bad != 0 || overlap != 0) begin
      n_bad++; $display("FAIL b5_busy_overlap got %0d/%0d exp 0/0", busy_bad, overlap);
    end
    n_cmp++;
    if (cs_low != 5 * (int'(AC) + 1) || oe_low != 5 * int'(AC)) begin
      n_bad++; $display("FAIL b5_strobes got cs=%0d oe=%0d exp cs=%0d oe=%0d",
                        cs_low, oe_low, 5 * (int'(AC) + 1), 5 * int'(AC));
    end
    n_cmp++;
    if (checksum !== CSUM5) begin
      n_bad++; $display("FAIL b5_checksum got %h exp %h", checksum, CSUM5);
    end
    n_cmp++;
  endtask

  task automatic test_wrap;
    logic [15:0] exp_a[3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    logic [7:0]  exp_d[3] = '{8'h77, 8'h88, 8'h01};
    run_burst(16'hFFFE, 8'd3, 40, -1);
    if (got_addr.size() != 3) begin
      n_bad++; $display("FAIL wrap_count got %0d exp 3", got_addr.size());
    end
    n_cmp++;
    for (int k = 0; k < 3 && k < got_addr.size(); k++) begin
      if (got_addr[k] !== exp_a[k] || got_data[k] !== exp_d[k]) begin
        n_bad++; $display("FAIL wrap_addr[%0d] got %h/%h exp %h/%h", k,
                          got_addr[k], got_data[k], exp_a[k], exp_d[k]);
      end
      n_cmp++;
    end
    if (done_cnt != 1 || busy_bad != 0) begin
      n_bad++; $display("FAIL wrap_done_busy got done=%0d busybad=%0d exp 1/0", done_cnt, busy_bad);
    end
    n_cmp++;
  endtask

  task automatic test_stall;
    int  w;
    int  bad;
    rd_ready = 1'b0;
    base_addr = 16'h0002; length = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!rd_valid && w < 20) begin
      @(negedge clk); w++;
    end
    if (!rd_valid) begin
      n_bad++; $display("FAIL stall_valid_timeout got 0 exp 1");
    end
    n_cmp++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rd_valid !== 1'b1 || rd_data !== 8'h06 || ee_cs_n !== 1'b1 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    if (bad != 0) begin
      n_bad++; $display("FAIL stall_hold got %0d bad cycles exp 0", bad);
    end
    n_cmp++;
    rd_ready = 1'b1;
    @(negedge clk);
    if (done !== 1'b1 || rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_done got done=%b v=%b exp 1/0", done, rd_valid);
    end
    n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_zero_len;
    base_addr = 16'h1234; length = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (done !== 1'b1 || busy !== 1'b0 || ee_cs_n !== 1'b1) begin
      n_bad++; $display("FAIL zero_len got done=%b busy=%b cs=%b exp 1/0/1", done, busy, ee_cs_n);
    end
    n_cmp++;
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0 || ee_cs_n !== 1'b1) begin
      n_bad++; $display("FAIL zero_len_after got done=%b busy=%b cs=%b exp 0/0/1", done, busy, ee_cs_n);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid;
    int w;
    int hs;
    int dseen;
    rd_ready = 1'b1;
    base_addr = 16'h0000; length = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0; hs = 0;
    // Second byte's ACCESS: output enable low after one byte was delivered.
    while (!(hs == 1 && !ee_oe_n) && w < 30) begin
      if (rd_valid) hs++;
      @(negedge clk); w++;
    end
    if (ee_addr !== 16'h0001 || ee_oe_n !== 1'b0) begin
      n_bad++; $display("FAIL rmid_reach got addr=%h oe=%b exp 0001/0", ee_addr, ee_oe_n);
    end
    n_cmp++;
    rst_n = 1'b0;
    #1;
    if ({ee_cs_n, ee_oe_n, ee_addr, rd_data, rd_valid, busy, done, checksum} !==
        {1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL rmid_reset got cs=%b oe=%b addr=%h data=%h v=%b busy=%b done=%b sum=%h",
               ee_cs_n, ee_oe_n, ee_addr, rd_data, rd_valid, busy, done, checksum);
    end
    n_cmp++;
    dseen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    if (dseen != 0) begin
      n_bad++; $display("FAIL rmid_no_done got %0d exp 0", dseen);
    end
    n_cmp++;
    run_burst(16'h0003, 8'd2, 30, -1);
    if (got_data.size() != 2 || got_data[0] !== 8'h0E || got_data[1] !== 8'h1A) begin
      n_bad++; $display("FAIL rmid_restart got n=%0d d0=%h d1=%h exp 2/0e/1a",
                        got_data.size(),
                        got_data.size() > 0 ? got_data[0] : 8'hxx,
                        got_data.size() > 1 ? got_data[1] : 8'hxx);
    end
    n_cmp++;
    if (checksum !== CSUM2 || done_cnt != 1) begin
      n_bad++; $display("FAIL rmid_sum got %h/%0d exp %h/1", checksum, done_cnt, CSUM2);
    end
    n_cmp++;
  endtask

  task automatic test_busy_start;
    logic [15:0] exp_a[3] = '{16'h0000, 16'h0001, 16'h0002};
    run_burst(16'h0000, 8'd3, 40, 3);
    if (got_addr.size() != 3 || done_cnt != 1) begin
      n_bad++; $display("FAIL busy_start_len got n=%0d done=%0d exp 3/1", got_addr.size(), done_cnt);
    end
    n_cmp++;
    for (int k = 0; k < 3 && k < got_addr.size(); k++) begin
      if (got_addr[k] !== exp_a[k]) begin
        n_bad++; $display("FAIL busy_start_addr[%0d] got %h exp %h", k, got_addr[k], exp_a[k]);
      end
      n_cmp++;
    end
    repeat (3) @(negedge clk);
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_start_idle got busy=%b exp 0", busy);
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_burst5();
    test_wrap();
    test_stall();
    test_zero_len();
    test_reset_mid();
    test_busy_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eeprom_reader.md
EEPROM_READER -- requirements
Module: eeprom_reader

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, number of cycles ee_oe_n is held low before ee_data is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a burst read; sampled only in IDLE.
REQ-005 base_addr  input  16  first EEPROM address of the burst; captured with start.
REQ-006 length  input  8  number of bytes to read (0..255); captured with start.
REQ-007 ee_cs_n  output  1  EEPROM chip select, active-low.
REQ-008 ee_oe_n  output  1  EEPROM output enable, active-low.
REQ-009 ee_addr  output  16  EEPROM address bus.
REQ-010 ee_data  input  8  EEPROM data bus; valid only while ee_cs_n and ee_oe_n are both low.
REQ-011 rd_data  output  8  byte delivered to the consumer.
REQ-012 rd_valid  output  1  rd_data holds a valid byte.
REQ-013 rd_ready  input  1  consumer accepts; a handshake occurs on an edge where rd_valid and rd_ready are both high.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 done  output  1  one-cycle pulse at burst completion.
REQ-016 checksum  output  8  running sum of delivered bytes (see Configuration).

Function
REQ-017 FSM states: IDLE, SETUP, ACCESS, HOLD.
REQ-018 IDLE with start=1 and length!=0:
- capture base_addr and length;
- go to SETUP.
REQ-019 IDLE with start=1 and length=0:
- stay IDLE;
- pulse done in the next cycle;
- no bus activity.
REQ-020 start while busy shall be ignored.
REQ-021 SETUP (exactly 1 cycle):
- ee_cs_n=0, ee_oe_n=1, ee_addr = current address;
- then go to ACCESS.
REQ-022 ACCESS (exactly ACCESS_CYCLES cycles):
- ee_cs_n=0, ee_oe_n=0, ee_addr stable;
- ee_data is registered into rd_data on the edge ending the last ACCESS cycle;
- rd_valid=1 from that edge;
- then go to HOLD.
REQ-023 HOLD:
- ee_cs_n=1, ee_oe_n=1;
- rd_valid and rd_data remain stable until handshake.
REQ-024 On handshake in HOLD:
- rd_valid=0 and remaining count decrements;
- if remaining becomes 0, go to IDLE and pulse done in the following cycle;
- otherwise increment the address and go to SETUP.
REQ-025 Address increment shall wrap modulo 2^16 (0xFFFF -> 0x0000).
REQ-026 With rd_ready held high, each byte shall take ACCESS_CYCLES+2 cycles; no bus gaps beyond HOLD.
REQ-027 ee_addr shall retain its last value when idle.
REQ-028 done and rd_valid shall never be high in the same cycle.

Reset
REQ-029 rst_n low shall immediately force the following, aborting any burst without a done pulse:
- state=IDLE;
- ee_cs_n=1, ee_oe_n=1, ee_addr=0x0000;
- rd_data=0x00, rd_valid=0, busy=0, done=0, checksum=0x00.
REQ-030 After rst_n deasserts, the first start shall be honoured normally.

Configuration
REQ-031 Macro EEPROM_READER_CHECKSUM_EN defined:
- checksum clears to 0x00 on an accepted start;
- adds each handshaken byte modulo 256;
- holds its value after done.
REQ-032 Macro EEPROM_READER_CHECKSUM_EN undefined: checksum port remains and is tied to 0x00.

Verification
REQ-033 Memory 0..4 = 01,03,06,0E,1A; base_addr=0x0000, length=5, rd_ready=1 -> rd_data sequence 01,03,06,0E,1A, each rd_valid 4 cycles apart, done one cycle after the 5th handshake, checksum=0x32 (with macro) or 0x00 (without).
REQ-034 base_addr=0xFFFE, length=3 -> ee_addr sequence FFFE, FFFF, 0000; busy high throughout; single done pulse.
REQ-035 length=1, rd_ready held low 10 cycles after rd_valid -> rd_valid and rd_data stable 10 cycles, ee_cs_n=1 during HOLD, done one cycle after handshake.
REQ-036 start with length=0 -> done pulse next cycle, ee_cs_n stays 1, busy stays 0.
REQ-037 rst_n low during ACCESS of byte 2 of a 5-byte burst -> outputs at reset values immediately, no done, next start with base_addr=0x0003, length=2 returns 0E,1A.
REQ-038 start pulsed while busy -> ignored; original burst length and addresses unchanged.
